// File: rtl/des_round_iter.sv
// Iterative DES round engine: one Feistel round per clock, 16 rounds per block.
// Expects IP-permuted input and produces the swapped preoutput for IP^-1.
module des_round_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] dat_in,
  output logic [3:0]  round_idx,
  input  logic [47:0] round_key,
  output logic        busy,
  output logic        done,
  output logic [63:0] dat_out
);

  typedef enum logic [0:0] {IDLE, RUN} state_t;

  // Each S-box is 64 nibbles, entry (row*16 + col) stored MSB-first.
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  localparam int P_TAB [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
  };

  // DES bit n maps to vector bit (width - n); the E table is the regular
  // "4 bits plus one neighbour on each side" pattern, so it is generated.
  function automatic logic [31:0] desF(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] e;
    logic [47:0] x;
    logic [31:0] s;
    logic [31:0] p;
    logic [5:0]  b;
    logic [5:0]  idx;
    e = '0;
    s = '0;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 6; j++) begin
        e[47 - (6 * i + j)] = r[31 - ((4 * i + j + 31) % 32)];
      end
    end
    x = e ^ k;
    for (int i = 0; i < 8; i++) begin
      b   = x[47 - 6 * i -: 6];
      idx = {b[5], b[0], b[4:1]};
      s[31 - 4 * i -: 4] = SBOX[i][255 - 4 * int'(idx) -: 4];
    end
    for (int n = 0; n < 32; n++) begin
      p[31 - n] = s[32 - P_TAB[n]];
    end
    return p;
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] l_q, l_d;
  logic [31:0] r_q, r_d;
  logic [63:0] out_q, out_d;
  logic        done_q, done_d;
  logic [31:0] f_out;

  assign f_out = desF(r_q, round_key);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      l_q     <= 32'd0;
      r_q     <= 32'd0;
      out_q   <= 64'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      l_q     <= l_d;
      r_q     <= r_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  // The last round writes the swapped halves straight into dat_out, so the
  // result is ready the cycle done rises and the counter never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    l_d     = l_q;
    r_d     = r_q;
    out_d   = out_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          l_d     = dat_in[63:32];
          r_d     = dat_in[31:0];
          cnt_d   = 4'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        l_d   = r_q;
        r_d   = l_q ^ f_out;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          out_d   = {l_q ^ f_out, r_q};
          done_d  = 1'b1;
          cnt_d   = 4'd0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q == RUN);
  assign round_idx = (state_q == RUN) ? cnt_q : 4'd0;
  assign done      = done_q;
  assign dat_out   = out_q;

endmodule
